truth_table_prober: RTL and testbench

//  Sequential characteriser for 3-input, 1-output logic cells such as the m0x.. truth-table modules.

---
 rtl/truth_table_prober_pkg.sv | 18 +
 rtl/truth_table_prober_if.sv | 26 ++
 rtl/truth_table_prober_acc.sv | 31 +++
 rtl/truth_table_prober.sv | 108 ++++++++++
 tb/tb_truth_table_prober.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_prober_pkg.sv
// Shared types and helpers for the 3-input truth-table prober.
package cello_probe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } probe_state_t;

    localparam int NUM_ROWS = 8;

    // Row 000 lands in the MSB so the code reads like a Wolfram rule number.
    function automatic logic [2:0] row_bit(input logic [2:0] row);
        return 3'd7 - row;
    endfunction

endpackage

// File: rtl/truth_table_prober_if.sv
// Controller-side port bundle of the prober; the state field is a debug tap.
interface truth_table_prober_if;
    import cello_probe_pkg::*;

    // start is a level request that is taken only while the prober is idle
    // (never queued); done pulses for one cycle when code/unstable are final.
    logic         start;
    logic [7:0]   expected;
    logic         busy;
    logic         done;
    logic [7:0]   code;
    logic [7:0]   unstable;
    logic         match;
    probe_state_t state;

    modport master (
        output start, expected,
        input  busy, done, code, unstable, match, state
    );

    modport slave (
        input  start, expected,
        output busy, done, code, unstable, match, state
    );

endinterface

// File: rtl/truth_table_prober_acc.sv
// Majority/stability accumulator over SAMPLES consecutive samples of one row.
module probe_sample_acc #(
    parameter int SAMPLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic maj,
    output logic unstable
);
    localparam int CW = $clog2(SAMPLES + 1);

    logic [CW-1:0] ones;
    logic [CW-1:0] ones_nx;

    // Outputs fold in the current sample so the row can be closed on its last one.
    assign ones_nx  = ones + CW'(bit_in);
    assign maj      = (ones_nx > CW'(SAMPLES / 2));
    assign unstable = (ones_nx != '0) && (ones_nx != CW'(SAMPLES));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            ones <= '0;
        end else if (en) begin
            ones <= ones_nx;
        end
    end

endmodule

// File: rtl/truth_table_prober.sv
// Sweeps a 3-input cell through all eight rows and assembles its function code.
module truth_table_prober
    import cello_probe_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_prober_if.slave  ctl,
    output logic [2:0]           probe_in,
    input  logic                 probe_out
);
    localparam int CMAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CW   = $clog2(CMAX + 1);

    probe_state_t  state;
    logic [2:0]    row;
    logic [CW-1:0] cnt;
    logic          sync1, sync2;
    logic          busy_r, done_r, match_r;
    logic [7:0]    code_r, unst_r;
    logic          acc_maj, acc_unst;

    probe_sample_acc #(.SAMPLES(SAMPLES)) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state != SAMPLE),
        .en       (state == SAMPLE),
        .bit_in   (sync2),
        .maj      (acc_maj),
        .unstable (acc_unst)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            row      <= 3'd0;
            cnt      <= '0;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            probe_in <= 3'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            match_r  <= 1'b0;
            code_r   <= 8'h00;
            unst_r   <= 8'h00;
        end else begin
            sync1  <= probe_out;
            sync2  <= sync1;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctl.start) begin
                        state    <= SETTLE;
                        row      <= 3'd0;
                        cnt      <= '0;
                        probe_in <= 3'd0;
                        code_r   <= 8'h00;
                        unst_r   <= 8'h00;
                        match_r  <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cnt == CW'(SAMPLES - 1)) begin
                        cnt                 <= '0;
                        code_r[row_bit(row)] <= acc_maj;
                        unst_r[row_bit(row)] <= acc_unst;
                        if (row == 3'(NUM_ROWS - 1)) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            row      <= row + 1'b1;
                            probe_in <= row + 1'b1;
                            state    <= SETTLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // expected is only looked at here, so it may change freely mid-sweep.
                    match_r <= (code_r == ctl.expected) && (unst_r == 8'h00);
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ctl.busy     = busy_r;
    assign ctl.done     = done_r;
    assign ctl.code     = code_r;
    assign ctl.unstable = unst_r;
    assign ctl.match    = match_r;
    assign ctl.state    = state;

endmodule

// File: tb/tb_truth_table_prober.sv
// Directed bench for truth_table_prober: two instances (default and 2/1 timing).
module tb_truth_table_prober;
    import cello_probe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    truth_table_prober_if ifa ();
    truth_table_prober_if ifb ();

    logic [2:0] pin_a, pin_b;
    logic       pout_a, pout_b;
    logic [7:0] cell_a = 8'hB1;
    logic [7:0] cell_b = 8'h96;
    logic       force0 = 1'b0;

    // Behavioural cells: out(row) = code[7-row]
    assign pout_a = force0 ? 1'b0 : cell_a[3'd7 - pin_a];
    assign pout_b = cell_b[3'd7 - pin_b];

    truth_table_prober #(.SETTLE_CYCLES(4), .SAMPLES(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .ctl(ifa.slave), .probe_in(pin_a), .probe_out(pout_a)
    );

    truth_table_prober #(.SETTLE_CYCLES(2), .SAMPLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ctl(ifb.slave), .probe_in(pin_b), .probe_out(pout_b)
    );

    int checks   = 0;
    int failures = 0;

    // Edges after the accept edge until done is seen: 8*(4+3)=56, i.e. cycle 57.
    localparam int DONE_A = 56;
    localparam int DONE_B = 24;

    int         done_edge, done_cnt, walk_err;
    logic [7:0] code_d, unst_d;
    logic       match_d, busy_d;

    task automatic run_sweep(input int glitch_edge, input int pulse_edge, input int budget);
        done_edge = -1;
        done_cnt  = 0;
        walk_err  = 0;
        match_d   = 1'bx;
        busy_d    = 1'bx;
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int n = 0; n <= budget; n++) begin
            if (n > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            ifa.start = (n == pulse_edge);
            force0    = (n == glitch_edge);
            if (n <= DONE_A - 1 && pin_a !== 3'(n / 7)) walk_err++;
            if (n >= DONE_A && pin_a !== 3'd7) walk_err++;
            if (ifa.done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = n;
                    code_d    = ifa.code;
                    unst_d    = ifa.unstable;
                end
            end
            if (done_edge >= 0 && n == done_edge + 1) begin
                match_d = ifa.match;
                busy_d  = ifa.busy;
            end
        end
        ifa.start = 1'b0;
        force0    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pin_a, ifa.busy, ifa.done, ifa.code, ifa.unstable, ifa.match} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got pin=%0d busy=%b done=%b code=%h unst=%h match=%b want all 0",
                     pin_a, ifa.busy, ifa.done, ifa.code, ifa.unstable, ifa.match);
        end
        checks++;
        if (ifa.state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got %0d want IDLE", ifa.state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_b1_cell();
        cell_a = 8'hB1;
        ifa.expected = 8'hB1;
        run_sweep(-1, -1, 60);
        checks++;
        if (done_edge !== DONE_A) begin
            failures++;
            $display("FAIL b1_latency got %0d want %0d", done_edge, DONE_A);
        end
        checks++;
        if (code_d !== 8'hB1) begin
            failures++;
            $display("FAIL b1_code got %h want b1", code_d);
        end
        checks++;
        if (unst_d !== 8'h00) begin
            failures++;
            $display("FAIL b1_unstable got %h want 00", unst_d);
        end
        checks++;
        if (match_d !== 1'b1 || busy_d !== 1'b0) begin
            failures++;
            $display("FAIL b1_match_busy got match=%b busy=%b want 1/0", match_d, busy_d);
        end
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL b1_done_count got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_zero_cell();
        cell_a = 8'h00;
        ifa.expected = 8'hB1;
        run_sweep(-1, -1, 60);
        checks++;
        if (code_d !== 8'h00 || match_d !== 1'b0) begin
            failures++;
            $display("FAIL zero_code got code=%h match=%b want 00/0", code_d, match_d);
        end
        checks++;
        if (walk_err !== 0) begin
            failures++;
            $display("FAIL zero_probe_walk got %0d bad cycles want 0", walk_err);
        end
        cell_a = 8'hB1;
    endtask

    // Row 3 starts at edge 21; a one-cycle dropout after edge 24 hits one sample.
    task automatic test_glitch();
        ifa.expected = 8'hB1;
        run_sweep(24, -1, 60);
        checks++;
        if (code_d !== 8'hB1) begin
            failures++;
            $display("FAIL glitch_code got %h want b1", code_d);
        end
        checks++;
        if (unst_d !== 8'h10) begin
            failures++;
            $display("FAIL glitch_unstable got %h want 10", unst_d);
        end
        checks++;
        if (match_d !== 1'b0) begin
            failures++;
            $display("FAIL glitch_match got %b want 0", match_d);
        end
    endtask

    // Row 2 is in SAMPLE after edges 18..20.
    task automatic test_start_ignored();
        ifa.expected = 8'hB1;
        run_sweep(-1, 18, 60);
        checks++;
        if (done_cnt !== 1 || done_edge !== DONE_A) begin
            failures++;
            $display("FAIL busy_start got done_cnt=%0d edge=%0d want 1/%0d", done_cnt, done_edge, DONE_A);
        end
        checks++;
        if (code_d !== 8'hB1 || match_d !== 1'b1) begin
            failures++;
            $display("FAIL busy_start_code got code=%h match=%b want b1/1", code_d, match_d);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (37) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pin_a !== 3'd5) begin
            failures++;
            $display("FAIL mid_row got %0d want 5", pin_a);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({pin_a, ifa.busy, ifa.done, ifa.code, ifa.unstable, ifa.match} !== 22'd0 || ifa.state !== IDLE) begin
            failures++;
            $display("FAIL mid_reset got pin=%0d busy=%b done=%b code=%h unst=%h match=%b state=%0d want 0/IDLE",
                     pin_a, ifa.busy, ifa.done, ifa.code, ifa.unstable, ifa.match, ifa.state);
        end
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL mid_no_done got %0d want 0", dones);
        end
        run_sweep(-1, -1, 60);
        checks++;
        if (done_edge !== DONE_A || code_d !== 8'hB1) begin
            failures++;
            $display("FAIL mid_restart got edge=%0d code=%h want %0d/b1", done_edge, code_d, DONE_A);
        end
    endtask

    // Held start: DONE exits at edge 57, IDLE accepts at 58, next done at 58+56.
    task automatic test_back_to_back();
        int first, second;
        first  = -1;
        second = -1;
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 130; n++) begin
            @(posedge clk);
            #1;
            if (ifa.done === 1'b1) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        @(negedge clk);
        ifa.start = 1'b0;
        checks++;
        if (first !== DONE_A || second !== DONE_A + 2 + DONE_A) begin
            failures++;
            $display("FAIL back_to_back got %0d,%0d want %0d,%0d", first, second, DONE_A, 2 * DONE_A + 2);
        end
        repeat (70) @(posedge clk);
    endtask

    task automatic test_small_config();
        int         edge_b;
        logic [7:0] code_b;
        logic       match_b;
        edge_b  = -1;
        code_b  = 8'hxx;
        match_b = 1'bx;
        ifb.expected = 8'h96;
        @(negedge clk);
        ifb.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifb.start = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ifb.done === 1'b1 && edge_b < 0) begin
                edge_b = n;
                code_b = ifb.code;
            end
            if (edge_b >= 0 && n == edge_b + 1) match_b = ifb.match;
        end
        checks++;
        if (edge_b !== DONE_B) begin
            failures++;
            $display("FAIL small_latency got %0d want %0d", edge_b, DONE_B);
        end
        checks++;
        if (code_b !== 8'h96 || match_b !== 1'b1) begin
            failures++;
            $display("FAIL small_code got code=%h match=%b want 96/1", code_b, match_b);
        end
    endtask

    initial begin
        ifa.start    = 1'b0;
        ifa.expected = 8'h00;
        ifb.start    = 1'b0;
        ifb.expected = 8'h00;
        test_reset();
        test_b1_cell();
        test_zero_cell();
        test_glitch();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_small_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
